// File: rtl/softplus_bwd.sv
// Backward pass of SoftPlus: dL/dx = dL/dy * sigmoid(x) in Q8.8, with a piecewise-linear
// sigmoid and one 16x16 multiplier shared between the sigmoid and gradient passes.
module softplus_bwd (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_x,
  input  logic [15:0] in_grad,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_data,
  output logic [15:0] out_sig
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SIG  = 2'd1;
  localparam logic [1:0] ST_MUL  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  logic [1:0]         state_q, state_d;
  logic signed [15:0] x_q, x_d;
  logic signed [15:0] grad_q, grad_d;
  logic signed [15:0] sig_q, sig_d;
  logic signed [15:0] data_q, data_d;

  logic signed [15:0] abs_x;
  logic signed [15:0] seg_s, seg_c;
  logic               seg_sat;
  logic signed [15:0] mul_a, mul_b;
  logic signed [31:0] prod;
  logic signed [15:0] y_abs;

  // |x| with the single unrepresentable magnitude clamped to the largest positive value.
  function automatic logic signed [15:0] abs_sat(input logic signed [15:0] v);
    if (v == 16'sh8000)
      return 16'sh7FFF;
    else if (v[15])
      return -v;
    else
      return v;
  endfunction

  // Q16.16 product back to Q8.8, rounding half toward +inf; the range of sig keeps it in 16 bits.
  function automatic logic signed [15:0] round_q88(input logic signed [31:0] p);
    logic signed [31:0] r;
    r = (p + 32'sd128) >>> 8;
    return r[15:0];
  endfunction

  assign abs_x = abs_sat(x_q);

  always_comb begin
    seg_s   = 16'sd64;
    seg_c   = 16'sd128;
    seg_sat = 1'b0;
    if (abs_x >= 16'sd1280) begin
      seg_sat = 1'b1;
    end else if (abs_x >= 16'sd608) begin
      seg_s = 16'sd8;
      seg_c = 16'sd216;
    end else if (abs_x >= 16'sd256) begin
      seg_s = 16'sd32;
      seg_c = 16'sd160;
    end
  end

  // Shared multiplier: slope*|x| while in SIG, sig*grad otherwise.
  always_comb begin
    if (state_q == ST_SIG) begin
      mul_a = seg_s;
      mul_b = abs_x;
    end else begin
      mul_a = sig_q;
      mul_b = grad_q;
    end
  end

  assign prod  = mul_a * mul_b;
  assign y_abs = seg_sat ? 16'sd256 : ($signed(prod[23:8]) + seg_c);

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    grad_d  = grad_q;
    sig_d   = sig_q;
    data_d  = data_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          x_d     = in_x;
          grad_d  = in_grad;
          state_d = ST_SIG;
        end
      end
      ST_SIG: begin
        sig_d   = x_q[15] ? (16'sd256 - y_abs) : y_abs;
        state_d = ST_MUL;
      end
      ST_MUL: begin
        data_d  = round_q88(prod);
        state_d = ST_DONE;
      end
      default: begin
        if (out_ready)
          state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      sig_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      sig_q   <= sig_d;
      data_q  <= data_d;
    end
  end

  // Operand latches need no reset: they are always written before being read.
  always_ff @(posedge clk) begin
    x_q    <= x_d;
    grad_q <= grad_d;
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign out_data  = data_q;
  assign out_sig   = sig_q;

endmodule

// File: tb/tb_softplus_bwd.sv
// Directed and random transactions for softplus_bwd, checked against an arithmetic model.
module tb_softplus_bwd;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_x = '0;
  logic [15:0] in_grad = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_data;
  logic [15:0] out_sig;

  int n_assert = 0;
  int n_fail   = 0;

  softplus_bwd dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_x      (in_x),
    .in_grad   (in_grad),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sig   (out_sig)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic int ref_sig(input int x);
    int a, y;
    a = (x < 0) ? -x : x;
    if (a > 32767) a = 32767;
    if (a >= 1280)     y = 256;
    else if (a >= 608) y = (8 * a) / 256 + 216;
    else if (a >= 256) y = (32 * a) / 256 + 160;
    else               y = (64 * a) / 256 + 128;
    return (x < 0) ? 256 - y : y;
  endfunction

  function automatic int ref_data(input int sig, input int grad);
    int p;
    p = sig * grad + 128;
    // Floor division by 256 on a signed value
    return (p >= 0) ? p / 256 : -((-p + 255) / 256);
  endfunction

  task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // One transaction: accept, verify latency, hold DONE for `hold` cycles, then complete.
  task automatic run_txn(input int x, input int grad, input int hold);
    int es, ed;
    es = ref_sig(x);
    ed = ref_data(es, grad);
    check("pre_in_ready", in_ready, 1);
    in_x      = x[15:0];
    in_grad   = grad[15:0];
    in_valid  = 1'b1;
    out_ready = (hold == 0);
    step();
    in_valid = 1'b0;
    check("lat_sig_vld", out_valid, 0);
    check("lat_sig_rdy", in_ready, 0);
    step();
    check("lat_mul_vld", out_valid, 0);
    step();
    check("done_vld", out_valid, 1);
    check("done_rdy", in_ready, 0);
    check("sig", $signed(out_sig), es);
    check("data", $signed(out_data), ed);
    for (int i = 0; i < hold; i++) begin
      step();
      check("hold_vld", out_valid, 1);
      check("hold_rdy", in_ready, 0);
      check("hold_sig", $signed(out_sig), es);
      check("hold_data", $signed(out_data), ed);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("post_vld", out_valid, 0);
    check("post_rdy", in_ready, 1);
  endtask

  // Accept a transaction, reset after `depth` cycles (1 = during SIG, 2 = during MUL).
  task automatic reset_midflight(input int depth);
    in_x     = 16'd700;
    in_grad  = 16'd1000;
    in_valid = 1'b1;
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    for (int i = 1; i < depth; i++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid_rst_vld", out_valid, 0);
    check("mid_rst_rdy", in_ready, 1);
    for (int i = 0; i < 4; i++) begin
      step();
      check("mid_rst_quiet", out_valid, 0);
    end
    out_ready = 1'b0;
    run_txn(-256, 512, 0);
  endtask

  initial begin
    int x, g;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    check("rst_vld", out_valid, 0);
    check("rst_data", $signed(out_data), 0);
    check("rst_sig", $signed(out_sig), 0);
    check("rst_rdy", in_ready, 1);

    run_txn(0, 256, 0);
    run_txn(256, 512, 0);
    run_txn(-256, 512, 0);
    run_txn(608, 256, 0);
    run_txn(607, 256, 0);
    run_txn(255, 256, 0);
    run_txn(1279, 1000, 0);
    run_txn(1280, -32768, 0);
    run_txn(-32768, -1000, 0);
    run_txn(32767, 32767, 0);
    run_txn(0, 3, 0);
    run_txn(0, -3, 0);
    run_txn(0, -1, 0);
    run_txn(-1000, -777, 5);

    reset_midflight(1);
    reset_midflight(2);

    for (int n = 0; n < 40; n++) begin
      if (n % 2 == 0) begin
        x = int'($urandom_range(0, 1600));
        if ($urandom_range(0, 1) == 1) x = -x;
      end else begin
        x = int'($signed(16'($urandom)));
      end
      g = int'($signed(16'($urandom)));
      run_txn(x, g, int'($urandom_range(0, 2)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
